sram_arbiter: RTL and testbench

Round-robin arbiter that shares one `sram_controller` (32-bit word port over the 16-bit asynchronous SRAM) among `NUM_REQ` requesters. It sits between the requesters and the controller's `memRead`/`memWrite`/`addrTarget`/`dataIn`/`ready`/`dataOut` port. It issues at most one outstanding 32-bit transaction and routes the completion back to the owning requester. It also rejects misaligned or out-of-range word addresses and applies a watchdog to every transaction.

---
 rtl/sram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one 32-bit sram_controller port among NUM_REQ
// requesters. One transaction is outstanding at a time. Misaligned or
// out-of-range word addresses are rejected without touching the SRAM, and a
// watchdog bounds the time spent waiting on the controller.
module sram_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic                      err,
   output logic [DATA_W-1:0]         rdata,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_ready,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = 10;
   // Last count value before the watchdog fires; the arbiter spends at most
   // TIMEOUT cycles in WAIT_BUSY + WAIT_DONE.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, REJECT} state_t;

   state_t             state, state_n;
   logic [PTR_W-1:0]   ptr, ptr_n;
   logic [PTR_W-1:0]   owner, owner_n;
   logic               we, we_n;
   logic [WD_W-1:0]    wdog, wdog_n;
   logic [NUM_REQ-1:0] gnt_n, done_n;
   logic               err_n, mem_read_n, mem_write_n;
   logic [DATA_W-1:0]  rdata_n, mem_wdata_n;
   logic [ADDR_W-1:0]  mem_addr_n;

   // Unflattened per-requester request fields
   logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
   logic [DATA_W-1:0] wdata_arr [NUM_REQ];

   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_unpack
         assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
         assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
      end
   endgenerate

   logic             found;
   logic [PTR_W-1:0] win, cand;
   logic [ADDR_W-1:0] win_addr;
   logic             legal;

   // Round-robin pick: first asserted req scanning from ptr with wrap
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Word access touches addr and addr+1: must be even and addr+1 must fit
   always_comb begin
      win_addr = addr_arr[win];
      legal    = (win_addr[0] == 1'b0) &&
                 (({1'b0, win_addr} + (ADDR_W+1)'(1)) <= {1'b0, {ADDR_W{1'b1}}});
   end

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      state_n     = state;
      ptr_n       = ptr;
      owner_n     = owner;
      we_n        = we;
      wdog_n      = wdog;
      gnt_n       = '0;
      done_n      = '0;
      err_n       = err;
      rdata_n     = rdata;
      mem_read_n  = 1'b0;
      mem_write_n = 1'b0;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      case (state)
         IDLE: begin
            // mem_ready gate also keeps us off a controller still busy
            // with a transaction the watchdog gave up on
            if (mem_ready && found) begin
               owner_n    = win;
               we_n       = req_we[win];
               gnt_n[win] = 1'b1;
               ptr_n      = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
               if (legal) begin
                  mem_addr_n  = win_addr;
                  mem_wdata_n = wdata_arr[win];
                  mem_write_n = req_we[win];
                  mem_read_n  = ~req_we[win];
                  state_n     = ISSUE;
               end else begin
                  state_n = REJECT;
               end
            end
         end
         ISSUE: begin
            wdog_n  = '0;
            state_n = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (wdog == WD_LAST) begin
               done_n[owner] = 1'b1;
               err_n         = 1'b1;
               rdata_n       = '0;
               state_n       = IDLE;
            end else begin
               wdog_n = wdog + 1'b1;
               if (!mem_ready) state_n = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // A real completion wins over a simultaneous timeout
            if (mem_ready) begin
               done_n[owner] = 1'b1;
               err_n         = 1'b0;
               rdata_n       = we ? '0 : mem_rdata;
               state_n       = IDLE;
            end else if (wdog == WD_LAST) begin
               done_n[owner] = 1'b1;
               err_n         = 1'b1;
               rdata_n       = '0;
               state_n       = IDLE;
            end else begin
               wdog_n = wdog + 1'b1;
            end
         end
         REJECT: begin
            done_n[owner] = 1'b1;
            err_n         = 1'b1;
            rdata_n       = '0;
            state_n       = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers; reset aborts any transaction silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         owner     <= '0;
         we        <= 1'b0;
         wdog      <= '0;
         gnt       <= '0;
         done      <= '0;
         err       <= 1'b0;
         rdata     <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         owner     <= owner_n;
         we        <= we_n;
         wdog      <= wdog_n;
         gnt       <= gnt_n;
         done      <= done_n;
         err       <= err_n;
         rdata     <= rdata_n;
         mem_read  <= mem_read_n;
         mem_write <= mem_write_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter with a behavioural stand-in for the sram_controller
// (halfword store, 3-cycle busy period) that can also hang ready high or low.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0, req_we = '0;
   logic [35:0] req_addr = '0;
   logic [127:0] req_wdata = '0;
   logic [3:0]  gnt, done;
   logic        err, mem_read, mem_write, mem_ready;
   logic [31:0] rdata, mem_wdata, mem_rdata;
   logic [8:0]  mem_addr;

   sram_arbiter #(.NUM_REQ(4), .ADDR_W(9), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   // Controller stand-in. mode 0: normal, 1: ready stuck high, 2: stuck low
   int          mode = 0;
   int          busy;
   logic        p_we;
   logic [8:0]  p_addr;
   logic [31:0] p_wd;
   logic [15:0] sram [0:511];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_ready <= 1'b1; busy <= 0; mem_rdata <= '0;
      end else if (mode == 2) mem_ready <= 1'b0;
      else if (mode == 1) mem_ready <= 1'b1;
      else if (busy != 0) begin
         busy <= busy - 1;
         if (busy == 1) begin
            mem_ready <= 1'b1;
            if (p_we) begin
               sram[p_addr] <= p_wd[15:0];
               sram[p_addr + 9'd1] <= p_wd[31:16];
            end else mem_rdata <= {sram[p_addr + 9'd1], sram[p_addr]};
         end
      end else if (mem_read || mem_write) begin
         mem_ready <= 1'b0; busy <= 3;
         p_we <= mem_write; p_addr <= mem_addr; p_wd <= mem_wdata;
      end else mem_ready <= 1'b1;
   end

   int rd_cnt = 0, wr_cnt = 0, done_total = 0;
   always @(negedge clk) begin
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (|done)     done_total++;
   end

   int total = 0, passed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      int          id;
      logic        we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic        exp_cmd;   // an SRAM command pulse is expected
      int          exp_lat;   // cycles from gnt to done
      logic        hang;      // controller ignores the command, ready stays high
   } vec_t;

   task automatic set_req(input int id, input logic we, input logic [8:0] a, input logic [31:0] d);
      req_we[id] = we;
      req_addr[id*9 +: 9] = a;
      req_wdata[id*32 +: 32] = d;
   endtask

   task automatic wait_gnt(output logic got);
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (|gnt) got = 1'b1;
      end
   endtask

   task automatic wait_done(output logic got, output int lat);
      got = 1'b0; lat = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         lat++;
         if (|done) got = 1'b1;
      end
   endtask

   task automatic do_txn(input vec_t v);
      logic got;
      int   lat, rd0, wr0;
      mode = v.hang ? 1 : 0;
      set_req(v.id, v.we, v.addr, v.wdata);
      rd0 = rd_cnt; wr0 = wr_cnt;
      req[v.id] = 1'b1;
      wait_gnt(got);
      check("gnt_seen", got, 1);
      check("gnt_owner", gnt, 64'(4'b0001 << v.id));
      check("rd_cmd_with_gnt", mem_read, v.exp_cmd && !v.we);
      check("wr_cmd_with_gnt", mem_write, v.exp_cmd && v.we);
      req[v.id] = 1'b0;
      wait_done(got, lat);
      check("done_seen", got, 1);
      check("done_owner", done, 64'(4'b0001 << v.id));
      check("err", err, v.exp_err);
      check("rdata", rdata, v.exp_rdata);
      check("gnt_to_done_cycles", lat, v.exp_lat);
      check("read_pulses", rd_cnt - rd0, (v.exp_cmd && !v.we) ? 1 : 0);
      check("write_pulses", wr_cnt - wr0, (v.exp_cmd && v.we) ? 1 : 0);
      mode = 0;
   endtask

   // Logged grant order and completions of a multi-requester sequence
   int          gq[$];
   int          dq_id[$];
   logic [31:0] dq_rdata[$];
   logic        dq_err[$];

   task automatic collect(input int n, input logic [3:0] keep_once);
      logic [3:0] keep;
      int nd;
      keep = keep_once; nd = 0;
      gq.delete(); dq_id.delete(); dq_rdata.delete(); dq_err.delete();
      for (int c = 0; c < 300 && nd < n; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (gnt[i]) begin
               gq.push_back(i);
               if (keep[i]) keep[i] = 1'b0; else req[i] = 1'b0;
            end
            if (done[i]) begin
               dq_id.push_back(i); dq_rdata.push_back(rdata); dq_err.push_back(err); nd++;
            end
         end
      end
      check("collect_done_count", nd, n);
   endtask

   vec_t vecs[11];
   int   fo[5] = '{0, 1, 2, 3, 0};
   logic [31:0] words[4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

   initial begin
      logic got, seen;
      int   lat, snap;

      vecs[0]  = '{0, 1'b1, 9'd4,   32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 5, 1'b0};
      vecs[1]  = '{0, 1'b0, 9'd4,   32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 5, 1'b0};
      vecs[2]  = '{2, 1'b0, 9'd5,   32'h0,        1'b1, 32'h0,        1'b0, 1, 1'b0};
      vecs[3]  = '{2, 1'b0, 9'd4,   32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 5, 1'b0};
      vecs[4]  = '{3, 1'b1, 9'd510, 32'hA5A55A5A, 1'b0, 32'h0,        1'b1, 5, 1'b0};
      vecs[5]  = '{3, 1'b0, 9'd510, 32'h0,        1'b0, 32'hA5A55A5A, 1'b1, 5, 1'b0};
      vecs[6]  = '{1, 1'b1, 9'd8,   32'hCAFEF00D, 1'b0, 32'h0,        1'b1, 5, 1'b0};
      vecs[7]  = '{3, 1'b1, 9'd3,   32'h12345678, 1'b1, 32'h0,        1'b0, 1, 1'b0};
      vecs[8]  = '{1, 1'b0, 9'd8,   32'h0,        1'b0, 32'hCAFEF00D, 1'b1, 5, 1'b0};
      vecs[9]  = '{0, 1'b0, 9'd4,   32'h0,        1'b1, 32'h0,        1'b1, 9, 1'b1};
      vecs[10] = '{1, 1'b0, 9'd511, 32'h0,        1'b1, 32'h0,        1'b0, 1, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_gnt_done", {gnt, done}, 0);
      check("reset_err_rdata", {err, rdata}, 0);
      check("reset_mem_cmd", {mem_read, mem_write, mem_addr, mem_wdata}, 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) do_txn(vecs[i]);

      // Controller goes stuck-busy after issue: watchdog completes with err,
      // then a new request must wait for ready before it is granted
      set_req(1, 1'b0, 9'd8, 32'h0);
      req[1] = 1'b1;
      wait_gnt(got);
      check("stuck_gnt_owner", gnt, 4'b0010);
      req[1] = 1'b0;
      mode = 2;
      wait_done(got, lat);
      check("stuck_done_owner", done, 4'b0010);
      check("stuck_err", err, 1);
      check("stuck_rdata", rdata, 0);
      check("stuck_cycles", lat, 9);
      set_req(2, 1'b0, 9'd4, 32'h0);
      req[2] = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (|gnt) seen = 1'b1;
      end
      check("stuck_no_gnt_while_busy", seen, 0);
      mode = 0;
      wait_gnt(got);
      check("stuck_gnt_after_ready", gnt, 4'b0100);
      req[2] = 1'b0;
      wait_done(got, lat);
      check("stuck_recover_rdata", rdata, 32'hDEADBEEF);
      check("stuck_recover_err", err, 0);

      // Pointer wrap: after req3 wins, req1 beats req2
      do_txn('{3, 1'b0, 9'd8, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, 5, 1'b0});
      set_req(1, 1'b0, 9'd8, 32'h0);
      set_req(2, 1'b0, 9'd4, 32'h0);
      req = 4'b0110;
      collect(2, 4'b0000);
      check("wrap_first", gq.size() > 0 ? gq[0] : -1, 1);
      check("wrap_second", gq.size() > 1 ? gq[1] : -1, 2);
      check("wrap_rdata0", dq_rdata.size() > 0 ? dq_rdata[0] : 0, 32'hCAFEF00D);
      check("wrap_rdata1", dq_rdata.size() > 1 ? dq_rdata[1] : 0, 32'hDEADBEEF);

      // Fairness: put ptr back at 0, then all four write at once, req0 re-requests
      do_txn('{3, 1'b0, 9'd510, 32'h0, 1'b0, 32'hA5A55A5A, 1'b1, 5, 1'b0});
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 9'(2*i), words[i]);
      req = 4'b1111;
      collect(5, 4'b0001);
      check("fair_grant_count", gq.size(), 5);
      for (int k = 0; k < 5; k++) check("fair_order", k < gq.size() ? gq[k] : -1, fo[k]);
      for (int k = 0; k < dq_err.size(); k++) check("fair_err", dq_err[k], 0);
      for (int i = 0; i < 4; i++)
         do_txn('{i, 1'b0, 9'(2*i), 32'h0, 1'b0, words[i], 1'b1, 5, 1'b0});

      // Reset during WAIT_DONE of a req2 read
      set_req(2, 1'b0, 9'd0, 32'h0);
      req[2] = 1'b1;
      wait_gnt(got);
      check("rst_op_gnt", gnt, 4'b0100);
      req[2] = 1'b0;
      repeat (2) @(negedge clk);
      snap = done_total;
      rst = 1'b1;
      #1;
      check("rst_mid_gnt_done", {gnt, done}, 0);
      check("rst_mid_err_rdata", {err, rdata}, 0);
      check("rst_mid_mem", {mem_read, mem_write, mem_addr, mem_wdata}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_no_done", done_total - snap, 0);
      set_req(1, 1'b0, 9'd8, 32'h0);
      set_req(3, 1'b0, 9'd6, 32'h0);
      req = 4'b1010;
      collect(2, 4'b0000);
      check("rst_first_gnt", gq.size() > 0 ? gq[0] : -1, 1);
      check("rst_second_gnt", gq.size() > 1 ? gq[1] : -1, 3);
      check("rst_rdata0", dq_rdata.size() > 0 ? dq_rdata[0] : 0, 32'hCAFEF00D);
      check("rst_rdata1", dq_rdata.size() > 1 ? dq_rdata[1] : 0, 32'h44444444);
      check("rst_err0", dq_err.size() > 0 ? dq_err[0] : 1'b1, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
